// File: rtl/dmem_cache_ctrl.sv
// MEM-stage data responder: direct-mapped, one word per line, write-through,
// no-write-allocate cache in front of a req/ack backing RAM.
// RAM handshake: ram_req rises with ram_addr/ram_we/ram_wdata and holds them stable;
// a one-cycle ram_ack while ram_req=1 completes the access and ram_req drops next cycle.
module dmem_cache_ctrl #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] WDONE = 2'd3;

  logic [1:0]          state;
  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem [LINES];
  logic [31:0]         data_mem [LINES];
  logic                just_filled;

  logic [INDEX_BITS-1:0] idx, fill_idx;
  logic [TAG_BITS-1:0]   req_tag, fill_tag;
  logic                  hit;

  assign idx      = mem_addr[INDEX_BITS+1:2];
  assign req_tag  = mem_addr[31:INDEX_BITS+2];
  assign fill_idx = ram_addr[INDEX_BITS+1:2];
  assign fill_tag = ram_addr[31:INDEX_BITS+2];
  assign hit      = valid[idx] && (tag_mem[idx] == req_tag);

  always_comb begin
    mem_stall = 1'b0;
    mem_din   = 32'd0;
    case (state)
      IDLE: begin
        if (mem_wen) begin
          mem_stall = 1'b1;
        end else if (mem_ren) begin
          if (hit) mem_din = data_mem[idx];
          else     mem_stall = 1'b1;
        end
      end
      FILL:    mem_stall = 1'b1;
      WRITE:   mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  // Line storage needs no reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (!rst && state == FILL && ram_ack) begin
      data_mem[fill_idx] <= ram_rdata;
      tag_mem[fill_idx]  <= fill_tag;
    end else if (!rst && state == IDLE && mem_wen && hit) begin
      data_mem[idx] <= mem_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      valid       <= '0;
      ram_req     <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= 32'd0;
      ram_wdata   <= 32'd0;
      hit_cnt     <= 32'd0;
      miss_cnt    <= 32'd0;
      just_filled <= 1'b0;
    end else begin
      just_filled <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_wen) begin
            state     <= WRITE;
            ram_req   <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= mem_addr & 32'hFFFF_FFFC;
            ram_wdata <= mem_dout;
          end else if (mem_ren) begin
            if (hit) begin
              // The re-lookup that completes a fill is not a fresh hit.
              if (!just_filled) hit_cnt <= hit_cnt + 32'd1;
            end else begin
              state    <= FILL;
              ram_req  <= 1'b1;
              ram_we   <= 1'b0;
              ram_addr <= mem_addr & 32'hFFFF_FFFC;
              miss_cnt <= miss_cnt + 32'd1;
            end
          end
        end
        FILL: begin
          if (ram_ack) begin
            valid[fill_idx] <= 1'b1;
            ram_req         <= 1'b0;
            just_filled     <= 1'b1;
            state           <= IDLE;
          end
        end
        WRITE: begin
          if (ram_ack) begin
            ram_req <= 1'b0;
            state   <= WDONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
